// File: rtl/boot_loader_pkg.sv
// Shared state encodings, default frame marker and checksum helper for the boot loader.
package boot_loader_pkg;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_ADDR_H = 4'd1,
    ST_ADDR_L = 4'd2,
    ST_LEN_H  = 4'd3,
    ST_LEN_L  = 4'd4,
    ST_DATA   = 4'd5,
    ST_CSUM   = 4'd6,
    ST_DONE   = 4'd7,
    ST_ERR    = 4'd8
  } boot_state_t;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

endpackage

// File: rtl/boot_timeout.sv
// Down-counter that flags expiry after TIMEOUT_CYCLES clocks; runs from reset,
// reloads on start and stops for good on stop. Used only when BOOT_TIMEOUT_EN is defined.
module boot_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 1_929_000
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic stop,
  output logic expire
);

  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0] LOAD = W'(TIMEOUT_CYCLES);

  logic [W-1:0] count;
  logic         running;

  // Count down while running; a stop freezes the counter until the next start or reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count   <= LOAD;
      running <= 1'b1;
    end else if (start) begin
      count   <= LOAD;
      running <= 1'b1;
    end else if (stop) begin
      running <= 1'b0;
    end else if (running && (count != {W{1'b0}})) begin
      count <= count - W'(1);
    end
  end

  assign expire = running && (count == W'(1));

endmodule

// File: rtl/boot_loader.sv
// Frame receiver that loads a program image into memory and holds the CPU until a good checksum.
// Optional feature: define BOOT_TIMEOUT_EN to release the CPU when no SYNC arrives in time.
module boot_loader
  import boot_loader_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE      = DEFAULT_SYNC_BYTE,
  parameter int unsigned TIMEOUT_CYCLES = 1_929_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wr_data,
  output logic        mem_wr_en,
  output logic        cpu_hold,
  output logic        boot_done,
  output logic        boot_err
);

  boot_state_t state;
  boot_state_t next_state;

  logic [15:0] addr_q;
  logic [15:0] len_q;
  logic [7:0]  csum_q;
  logic        is_sync;
  logic        sync_in_idle;
  logic        timeout_expire;
  logic        enter_done;
  logic        enter_err;

  assign is_sync      = rx_valid && (rx_data == SYNC_BYTE);
  assign sync_in_idle = is_sync && (state == ST_IDLE);

`ifdef BOOT_TIMEOUT_EN
  boot_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .start  (1'b0),
    .stop   (sync_in_idle),
    .expire (timeout_expire)
  );
`else
  // No timeout in this build; the parameter is only referenced to keep the interface uniform.
  assign timeout_expire = 1'b0 & (TIMEOUT_CYCLES == 32'd0);
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; only received bytes advance the frame, except the idle timeout.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (is_sync) begin
          next_state = ST_ADDR_H;
        end else if (timeout_expire) begin
          next_state = ST_DONE;
        end else begin
          next_state = ST_IDLE;
        end
      end
      ST_ADDR_H: next_state = rx_valid ? ST_ADDR_L : ST_ADDR_H;
      ST_ADDR_L: next_state = rx_valid ? ST_LEN_H  : ST_ADDR_L;
      ST_LEN_H:  next_state = rx_valid ? ST_LEN_L  : ST_LEN_H;
      ST_LEN_L: begin
        if (rx_valid) begin
          next_state = ({len_q[15:8], rx_data} == 16'd0) ? ST_CSUM : ST_DATA;
        end else begin
          next_state = ST_LEN_L;
        end
      end
      ST_DATA: begin
        if (rx_valid && (len_q == 16'd1)) begin
          next_state = ST_CSUM;
        end else begin
          next_state = ST_DATA;
        end
      end
      ST_CSUM: begin
        if (rx_valid) begin
          next_state = (rx_data == csum_q) ? ST_DONE : ST_ERR;
        end else begin
          next_state = ST_CSUM;
        end
      end
      ST_DONE: next_state = ST_DONE;
      ST_ERR:  next_state = is_sync ? ST_ADDR_H : ST_ERR;
      default: next_state = ST_IDLE;
    endcase
  end

  assign enter_done = (next_state == ST_DONE) && (state != ST_DONE);
  assign enter_err  = (next_state == ST_ERR)  && (state != ST_ERR);

  // Frame datapath: header latches, checksum accumulator and the registered write port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q      <= 16'h0000;
      len_q       <= 16'h0000;
      csum_q      <= 8'h00;
      mem_addr    <= 16'h0000;
      mem_wr_data <= 8'h00;
      mem_wr_en   <= 1'b0;
    end else begin
      mem_wr_en <= 1'b0;
      if (rx_valid) begin
        case (state)
          ST_IDLE, ST_ERR: begin
            if (is_sync) begin
              csum_q <= 8'h00;
            end
          end
          ST_ADDR_H: begin
            addr_q[15:8] <= rx_data;
            csum_q       <= csum_add(csum_q, rx_data);
          end
          ST_ADDR_L: begin
            addr_q[7:0] <= rx_data;
            csum_q      <= csum_add(csum_q, rx_data);
          end
          ST_LEN_H: begin
            len_q[15:8] <= rx_data;
            csum_q      <= csum_add(csum_q, rx_data);
          end
          ST_LEN_L: begin
            len_q[7:0] <= rx_data;
            csum_q     <= csum_add(csum_q, rx_data);
          end
          ST_DATA: begin
            mem_wr_en   <= 1'b1;
            mem_addr    <= addr_q;
            mem_wr_data <= rx_data;
            addr_q      <= addr_q + 16'd1;
            len_q       <= len_q - 16'd1;
            csum_q      <= csum_add(csum_q, rx_data);
          end
          default: begin
          end
        endcase
      end
    end
  end

  // Status flags: done is sticky until reset, error clears on the retry SYNC.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_hold  <= 1'b1;
      boot_done <= 1'b0;
      boot_err  <= 1'b0;
    end else begin
      if (enter_done) begin
        boot_done <= 1'b1;
        cpu_hold  <= 1'b0;
      end
      if (enter_err) begin
        boot_err <= 1'b1;
      end else if ((state == ST_ERR) && is_sync) begin
        boot_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// Scoreboard bench for boot_loader: expected writes are queued by the stimulus and
// checked by an independent monitor, including the one-cycle write latency.
module tb_boot_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wr_data;
  logic        mem_wr_en;
  logic        cpu_hold;
  logic        boot_done;
  logic        boot_err;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
    int          cyc;
  } wr_t;

  wr_t sb[$];
  int  tests = 0;
  int  fails = 0;
  int  pc = 0;

  boot_loader #(
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .mem_addr    (mem_addr),
    .mem_wr_data (mem_wr_data),
    .mem_wr_en   (mem_wr_en),
    .cpu_hold    (cpu_hold),
    .boot_done   (boot_done),
    .boot_err    (boot_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) pc <= pc + 1;

  // Monitor: every write strobe must match the oldest queued write, on the expected cycle.
  always @(negedge clk) begin
    if (!reset && mem_wr_en) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write: got addr=%h data=%h, expected no write", mem_addr, mem_wr_data);
      end else begin
        wr_t e;
        e = sb.pop_front();
        if (mem_addr !== e.addr || mem_wr_data !== e.data || pc != e.cyc) begin
          fails++;
          $display("FAIL write: got addr=%h data=%h cyc=%0d, expected addr=%h data=%h cyc=%0d",
                   mem_addr, mem_wr_data, pc, e.addr, e.data, e.cyc);
        end
      end
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
  endtask

  task automatic send_wr(input logic [7:0] b, input logic [15:0] a);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    sb.push_back('{a, b, pc + 1});
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_addr"}, mem_addr, 16'h0000);
    check({tag, "_wdata"}, {8'h00, mem_wr_data}, 16'h0000);
    check({tag, "_wren"}, {15'd0, mem_wr_en}, 16'd0);
    check({tag, "_hold"}, {15'd0, cpu_hold}, 16'd1);
    check({tag, "_done"}, {15'd0, boot_done}, 16'd0);
    check({tag, "_err"}, {15'd0, boot_err}, 16'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    rx_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check_status(input string tag, input logic done, input logic hold, input logic err);
    check({tag, "_done"}, {15'd0, boot_done}, {15'd0, done});
    check({tag, "_hold"}, {15'd0, cpu_hold}, {15'd0, hold});
    check({tag, "_err"}, {15'd0, boot_err}, {15'd0, err});
  endtask

  // Valid frame for 0x0010: checksum 00+10+00+02+11+22 = 0x45.
  task automatic frame_good_0010();
    send(8'hA5); send(8'h00); send(8'h10); send(8'h00); send(8'h02);
    send_wr(8'h11, 16'h0010); send_wr(8'h22, 16'h0011);
    send(8'h45);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (2) @(negedge clk);
    check_reset_values("por");
    reset = 1'b0;

    // Good frame, then a further frame that must be ignored once done.
    frame_good_0010();
    idle(3);
    check_status("t1", 1'b1, 1'b0, 1'b0);
    send(8'hA5); send(8'h00); send(8'h20); send(8'h00); send(8'h01); send(8'h33); send(8'h54);
    idle(3);
    check_status("t1_ignore", 1'b1, 1'b0, 1'b0);

    // Bad checksum: writes still happen, CPU stays held; retry clears the error.
    do_reset();
    send(8'hA5); send(8'h00); send(8'h10); send(8'h00); send(8'h02);
    send_wr(8'h11, 16'h0010); send_wr(8'h22, 16'h0011);
    send(8'h00);
    idle(3);
    check_status("t2_bad", 1'b0, 1'b1, 1'b1);
    frame_good_0010();
    idle(3);
    check_status("t2_retry", 1'b1, 1'b0, 1'b0);

    // Noise before SYNC, then an address-wrapping frame: FF+FF+00+02+01+02 = 0x03.
    do_reset();
    send(8'h00); send(8'hFF); send(8'h12);
    idle(3);
    check_status("t3_noise", 1'b0, 1'b1, 1'b0);
    send(8'hA5); send(8'hFF); send(8'hFF); send(8'h00); send(8'h02);
    send_wr(8'h01, 16'hFFFF); send_wr(8'h02, 16'h0000);
    send(8'h03);
    idle(3);
    check_status("t3_wrap", 1'b1, 1'b0, 1'b0);

    // Zero-length frame, then reset in the middle of a header.
    do_reset();
    send(8'hA5); send(8'h12); send(8'h34); send(8'h00); send(8'h00); send(8'h46);
    idle(3);
    check_status("t4_len0", 1'b1, 1'b0, 1'b0);
    do_reset();
    send(8'hA5); send(8'hAB); send(8'hCD); send(8'h00);
    @(negedge clk);
    reset    = 1'b1;
    rx_valid = 1'b0;
    #1;
    check_reset_values("midrst");
    @(negedge clk);
    reset = 1'b0;
    // Fresh frame after the abort: 00+40+00+01+77 = 0xB8.
    send(8'hA5); send(8'h00); send(8'h40); send(8'h00); send(8'h01);
    send_wr(8'h77, 16'h0040);
    send(8'hB8);
    idle(3);
    check_status("t4_fresh", 1'b1, 1'b0, 1'b0);

`ifdef BOOT_TIMEOUT_EN
    // Timeout with no input releases the CPU on cycle 100 after reset.
    do_reset();
    r = pc;
    while (pc < r + 99) @(negedge clk);
    check_status("t5_before", 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    check_status("t5_expire", 1'b1, 1'b0, 1'b0);
    // A SYNC at cycle 50 stops the timer for good.
    do_reset();
    r = pc;
    while (pc < r + 49) @(negedge clk);
    send(8'hA5);
    idle(1);
    while (pc < r + 150) @(negedge clk);
    check_status("t5_sync", 1'b0, 1'b1, 1'b0);
`else
    r = 0;
`endif

    idle(2);
    check("pending_writes", 16'(sb.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
